// File: rtl/commit_trace_buf_if.sv
// Port bundle for the retirement-trace buffer.
// Covers the commit/flush capture side, trigger control, status and the drain stream.
interface commit_trace_buf_if #(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 32,
    parameter int PC_W     = 32,
    parameter int AREG_W   = 5,
    parameter int PREG_W   = 6,
    parameter int CYC_W    = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [COMMIT_W-1:0]             commit_valid;
    logic [COMMIT_W-1:0][PC_W-1:0]   commit_pc;
    logic [COMMIT_W-1:0][AREG_W-1:0] commit_arch_rd;
    logic [COMMIT_W-1:0][PREG_W-1:0] commit_phys_rd;
    logic [COMMIT_W-1:0]             commit_is_load;
    logic [COMMIT_W-1:0]             commit_is_store;
    logic                            flush_valid;
    logic [PC_W-1:0]                 flush_pc;
    logic                            arm;
    logic                            abort;
    logic                            trig_pc_en;
    logic [PC_W-1:0]                 trig_pc;
    logic                            trig_flush_en;
    logic [CW-1:0]                   post_count;
    logic [1:0]                      state;
    logic [CW-1:0]                   fill_level;
    logic                            wrapped;
    logic                            rd_valid;
    logic                            rd_ready;
    logic                            rd_kind;
    logic [CYC_W-1:0]                rd_stamp;
    logic [PC_W-1:0]                 rd_pc;
    logic [AREG_W-1:0]               rd_arch_rd;
    logic [PREG_W-1:0]               rd_phys_rd;
    logic                            rd_ld;
    logic                            rd_st;

    modport master (
        output commit_valid, commit_pc, commit_arch_rd, commit_phys_rd,
               commit_is_load, commit_is_store, flush_valid, flush_pc,
               arm, abort, trig_pc_en, trig_pc, trig_flush_en, post_count, rd_ready,
        input  state, fill_level, wrapped, rd_valid, rd_kind, rd_stamp, rd_pc,
               rd_arch_rd, rd_phys_rd, rd_ld, rd_st
    );

    modport slave (
        input  commit_valid, commit_pc, commit_arch_rd, commit_phys_rd,
               commit_is_load, commit_is_store, flush_valid, flush_pc,
               arm, abort, trig_pc_en, trig_pc, trig_flush_en, post_count, rd_ready,
        output state, fill_level, wrapped, rd_valid, rd_kind, rd_stamp, rd_pc,
               rd_arch_rd, rd_phys_rd, rd_ld, rd_st
    );
endinterface

// File: rtl/commit_trace_buf.sv
// Retirement-trace capture buffer: records commits and flushes into a circular buffer,
// freezes a window around a PC/flush trigger, then drains it oldest-first.
module commit_trace_buf #(
    parameter int COMMIT_W = 2,
    parameter int DEPTH    = 32,
    parameter int PC_W     = 32,
    parameter int AREG_W   = 5,
    parameter int PREG_W   = 6,
    parameter int CYC_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    commit_trace_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        POST   = 2'd2,
        FROZEN = 2'd3
    } state_t;

    state_t           r_state, w_next_state;
    logic [PW-1:0]    r_wr_ptr, w_wr_ptr_next;
    logic [CW-1:0]    r_fill, w_fill_next;
    logic [CW-1:0]    r_remain, w_remain_next;
    logic             r_wrapped, w_wrapped_next;
    logic [CYC_W-1:0] r_stamp;

    logic              r_mem_kind  [DEPTH];
    logic [CYC_W-1:0]  r_mem_stamp [DEPTH];
    logic [PC_W-1:0]   r_mem_pc    [DEPTH];
    logic [AREG_W-1:0] r_mem_arch  [DEPTH];
    logic [PREG_W-1:0] r_mem_phys  [DEPTH];
    logic              r_mem_ld    [DEPTH];
    logic              r_mem_st    [DEPTH];

    logic [PW-1:0] w_lane_off [COMMIT_W];
    logic [PW-1:0] w_flush_off;
    logic [CW-1:0] w_n;
    logic          w_match;
    logic [CW-1:0] w_match_pos;
    logic [CW-1:0] w_after;
    logic [CW:0]   w_fill_sum;
    logic          w_wr_en;
    logic          w_rd_valid;
    logic [PW-1:0] w_rd_ptr;

    // Compact valid lanes into consecutive slots and locate the first trigger hit.
    always_comb begin
        w_flush_off = '0;
        w_match     = 1'b0;
        w_match_pos = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            w_lane_off[i] = w_flush_off;
            if (bus.commit_valid[i]) begin
                if (!w_match && bus.trig_pc_en && (bus.commit_pc[i] == bus.trig_pc)) begin
                    w_match     = 1'b1;
                    w_match_pos = CW'(w_flush_off);
                end
                w_flush_off = w_flush_off + PW'(1);
            end
        end
        if (!w_match && bus.flush_valid && bus.trig_flush_en) begin
            w_match     = 1'b1;
            w_match_pos = CW'(w_flush_off);
        end
        w_n = CW'(w_flush_off) + CW'(bus.flush_valid);
    end

    assign w_after    = w_n - w_match_pos - CW'(1);
    assign w_fill_sum = {1'b0, r_fill} + {1'b0, w_n};
    assign w_wr_en    = ((r_state == ARMED) || (r_state == POST)) && !bus.abort;

    always_comb begin
        w_next_state   = r_state;
        w_wr_ptr_next  = r_wr_ptr;
        w_fill_next    = r_fill;
        w_remain_next  = r_remain;
        w_wrapped_next = r_wrapped;
        if (bus.abort) begin
            w_next_state = IDLE;
            w_fill_next  = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.arm) begin
                        w_next_state   = ARMED;
                        w_fill_next    = '0;
                        w_wrapped_next = 1'b0;
                        w_remain_next  = bus.post_count;
                    end
                end
                ARMED, POST: begin
                    w_wr_ptr_next = r_wr_ptr + w_n[PW-1:0];
                    if (w_fill_sum > (CW+1)'(DEPTH)) begin
                        w_fill_next    = CW'(DEPTH);
                        w_wrapped_next = 1'b1;
                    end else begin
                        w_fill_next = w_fill_sum[CW-1:0];
                    end
                    if (r_state == ARMED) begin
                        if (w_match) begin
                            if (r_remain <= w_after) begin
                                w_next_state  = FROZEN;
                                w_remain_next = '0;
                            end else begin
                                w_next_state  = POST;
                                w_remain_next = r_remain - w_after;
                            end
                        end
                    end else if (r_remain <= w_n) begin
                        w_next_state  = FROZEN;
                        w_remain_next = '0;
                    end else begin
                        w_remain_next = r_remain - w_n;
                    end
                end
                FROZEN: begin
                    if (r_fill == '0) begin
                        w_next_state = IDLE;
                    end else if (bus.rd_ready) begin
                        w_fill_next = r_fill - CW'(1);
                        if (r_fill == CW'(1)) begin
                            w_next_state = IDLE;
                        end
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_wr_ptr  <= '0;
            r_fill    <= '0;
            r_remain  <= '0;
            r_wrapped <= 1'b0;
            r_stamp   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_wr_ptr  <= w_wr_ptr_next;
            r_fill    <= w_fill_next;
            r_remain  <= w_remain_next;
            r_wrapped <= w_wrapped_next;
            r_stamp   <= r_stamp + CYC_W'(1);
        end
    end

    // Array needs no reset: only entries counted by fill level are ever presented.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (bus.commit_valid[i]) begin
                    r_mem_kind [r_wr_ptr + w_lane_off[i]] <= 1'b0;
                    r_mem_stamp[r_wr_ptr + w_lane_off[i]] <= r_stamp;
                    r_mem_pc   [r_wr_ptr + w_lane_off[i]] <= bus.commit_pc[i];
                    r_mem_arch [r_wr_ptr + w_lane_off[i]] <= bus.commit_arch_rd[i];
                    r_mem_phys [r_wr_ptr + w_lane_off[i]] <= bus.commit_phys_rd[i];
                    r_mem_ld   [r_wr_ptr + w_lane_off[i]] <= bus.commit_is_load[i];
                    r_mem_st   [r_wr_ptr + w_lane_off[i]] <= bus.commit_is_store[i];
                end
            end
            if (bus.flush_valid) begin
                r_mem_kind [r_wr_ptr + w_flush_off] <= 1'b1;
                r_mem_stamp[r_wr_ptr + w_flush_off] <= r_stamp;
                r_mem_pc   [r_wr_ptr + w_flush_off] <= bus.flush_pc;
                r_mem_arch [r_wr_ptr + w_flush_off] <= '0;
                r_mem_phys [r_wr_ptr + w_flush_off] <= '0;
                r_mem_ld   [r_wr_ptr + w_flush_off] <= 1'b0;
                r_mem_st   [r_wr_ptr + w_flush_off] <= 1'b0;
            end
        end
    end

    assign w_rd_valid = (r_state == FROZEN) && (r_fill != '0);
    assign w_rd_ptr   = r_wr_ptr - r_fill[PW-1:0];

    assign bus.state      = r_state;
    assign bus.fill_level = r_fill;
    assign bus.wrapped    = r_wrapped;
    assign bus.rd_valid   = w_rd_valid;
    assign bus.rd_kind    = w_rd_valid & r_mem_kind[w_rd_ptr];
    assign bus.rd_stamp   = w_rd_valid ? r_mem_stamp[w_rd_ptr] : '0;
    assign bus.rd_pc      = w_rd_valid ? r_mem_pc[w_rd_ptr] : '0;
    assign bus.rd_arch_rd = w_rd_valid ? r_mem_arch[w_rd_ptr] : '0;
    assign bus.rd_phys_rd = w_rd_valid ? r_mem_phys[w_rd_ptr] : '0;
    assign bus.rd_ld      = w_rd_valid & r_mem_ld[w_rd_ptr];
    assign bus.rd_st      = w_rd_valid & r_mem_st[w_rd_ptr];
endmodule
